// File: rtl/dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// dispatcher_pkg
// Shared definitions for the instruction dispatcher: instruction field
// positions, opcode values, FSM state encoding and an opcode classifier.
// -----------------------------------------------------------------------------
package dispatcher_pkg;

    // Instruction layout: [63:60] opcode, [59:0] payload
    localparam int INSTR_W   = 64;
    localparam int OPC_HI    = 63;
    localparam int OPC_LO    = 60;
    localparam int OPC_W     = OPC_HI - OPC_LO + 1;
    localparam int PAYLOAD_W = 60;

    localparam logic [OPC_W-1:0] OP_NOP     = 4'h0;
    localparam logic [OPC_W-1:0] OP_LOAD    = 4'h1;
    localparam logic [OPC_W-1:0] OP_CONV    = 4'h2;
    localparam logic [OPC_W-1:0] OP_POOL    = 4'h3;
    localparam logic [OPC_W-1:0] OP_STORE   = 4'h4;
    localparam logic [OPC_W-1:0] OP_BARRIER = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT    = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_NOP,
        K_UNIT,
        K_BARRIER,
        K_HALT,
        K_ILLEGAL
    } opc_kind_t;

    // Unit opcodes occupy 1..num_units; the unit index is opcode-1.
    function automatic opc_kind_t classify(input logic [OPC_W-1:0] opc,
                                           input int num_units);
        if (opc == OP_NOP)
            return K_NOP;
        else if (opc == OP_BARRIER)
            return K_BARRIER;
        else if (opc == OP_HALT)
            return K_HALT;
        else if (int'(opc) <= num_units)
            return K_UNIT;
        else
            return K_ILLEGAL;
    endfunction

endpackage

// File: rtl/dispatch_timeout_cnt.sv
// -----------------------------------------------------------------------------
// dispatch_timeout_cnt
// Saturating per-instruction wait counter. Cleared when a unit is started,
// advanced once per cycle spent waiting for completion.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-high reset
//   i_clear   zero the count (takes priority over i_enable)
//   i_enable  advance the count this cycle
//   o_tc      terminal count: this increment makes the count all-ones
// -----------------------------------------------------------------------------
module dispatch_timeout_cnt #(
    parameter int TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [TIMEOUT_W-1:0] r_cnt;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + TIMEOUT_W'(1);
    end

    // Waiting cycle n (n = 1, 2, ...) sees a count of n-1, so the cycle that
    // carries the count to all-ones is the (2^W - 1)-th waiting cycle.
    assign o_tc = i_enable && (r_cnt >= (CNT_MAX - TIMEOUT_W'(1)));

endmodule

// File: rtl/instr_dispatcher.sv
// -----------------------------------------------------------------------------
// instr_dispatcher
// Captures instructions from the fetch FSM, starts the addressed execution
// unit once it is free, waits for its completion and reports retirement.
// Handles NOP, BARRIER (drain all units), HALT, illegal opcodes and timeouts.
//
// Ports:
//   clk                   system clock
//   rst                   asynchronous, active-high reset
//   i_instruction_enable  one-cycle pulse, i_ctr valid in the same cycle
//   i_ctr                 instruction: [63:60] opcode, [59:0] payload
//   i_unit_busy           per-unit busy level
//   i_unit_done           per-unit one-cycle completion pulse
//   o_unit_start          one-hot, one-cycle start pulse
//   o_unit_param          payload of the issued instruction, held until next issue
//   o_instr_exe_state     one-cycle pulse: current instruction retired
//   o_halted              HALT reached, sticky until reset
//   o_err_illegal         sticky: undefined opcode seen
//   o_err_timeout         sticky: unit did not complete in time
//   o_err_overrun         sticky: instruction_enable while not idle
//   o_dispatcher_idle     high while idle
// -----------------------------------------------------------------------------
module instr_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_instruction_enable,
    input  logic [INSTR_W-1:0]   i_ctr,
    input  logic [NUM_UNITS-1:0] i_unit_busy,
    input  logic [NUM_UNITS-1:0] i_unit_done,
    output logic [NUM_UNITS-1:0] o_unit_start,
    output logic [PAYLOAD_W-1:0] o_unit_param,
    output logic                 o_instr_exe_state,
    output logic                 o_halted,
    output logic                 o_err_illegal,
    output logic                 o_err_timeout,
    output logic                 o_err_overrun,
    output logic                 o_dispatcher_idle
);

    state_t                r_state;
    state_t                w_next_state;
    logic [INSTR_W-1:0]    r_instr;

    logic [OPC_W-1:0]      w_opc;
    logic [PAYLOAD_W-1:0]  w_payload;
    opc_kind_t             w_kind;
    logic [NUM_UNITS-1:0]  w_tgt_oh;
    logic                  w_tgt_busy;
    logic                  w_tgt_done;
    logic                  w_cnt_clear;
    logic                  w_cnt_enable;
    logic                  w_tc;

    // Registered outputs and their next values
    logic [NUM_UNITS-1:0]  r_unit_start,    w_unit_start;
    logic [PAYLOAD_W-1:0]  r_unit_param,    w_unit_param;
    logic                  r_exe,           w_exe;
    logic                  r_halted,        w_halted;
    logic                  r_idle,          w_idle;
    logic                  r_err_illegal,   w_illegal_set;
    logic                  r_err_timeout,   w_timeout_set;
    logic                  r_err_overrun,   w_overrun_set;

    // ---------------------------------------------------------------- decode
    assign w_opc     = r_instr[OPC_HI:OPC_LO];
    assign w_payload = r_instr[PAYLOAD_W-1:0];
    assign w_kind    = classify(w_opc, NUM_UNITS);

    // NOTE: every signal written in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_tgt_oh = '0;
        if (w_kind == K_UNIT)
            w_tgt_oh = NUM_UNITS'(1) << (w_opc - OP_LOAD);
    end

    // Completion and busy bits of units other than the target are ignored.
    assign w_tgt_busy = |(i_unit_busy & w_tgt_oh);
    assign w_tgt_done = |(i_unit_done & w_tgt_oh);

    // --------------------------------------------------------- wait counter
    assign w_cnt_clear  = (r_state == S_ISSUE);
    assign w_cnt_enable = (r_state == S_WAIT) && !w_tgt_done;

    dispatch_timeout_cnt #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_enable),
        .o_tc     (w_tc)
    );

    // ------------------------------------------------------ instruction reg
    // Only captured in IDLE; an enable in any other state leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_instr <= '0;
        else if ((r_state == S_IDLE) && i_instruction_enable)
            r_instr <= i_ctr;
    end

    // -------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:
                if (i_instruction_enable)
                    w_next_state = S_DECODE;
            S_DECODE:
                unique case (w_kind)
                    K_NOP:     w_next_state = S_DONE;
                    K_UNIT:    w_next_state = w_tgt_busy ? S_DECODE : S_ISSUE;
                    K_BARRIER: w_next_state = S_DRAIN;
                    K_HALT:    w_next_state = S_HALT;
                    default:   w_next_state = S_DONE;   // illegal: skip, still retire
                endcase
            S_ISSUE:
                w_next_state = S_WAIT;
            S_WAIT:
                // Completion is checked first so it wins over a same-cycle timeout.
                if (w_tgt_done || w_tc)
                    w_next_state = S_DONE;
            S_DRAIN:
                if (i_unit_busy == '0)
                    w_next_state = S_DONE;
            S_DONE:
                w_next_state = S_IDLE;
            S_HALT:
                w_next_state = S_HALT;
            default:
                w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------- output logic
    // Outputs are computed from the state being entered and registered, so
    // each one is valid in the same cycle as the state it belongs to.
    always_comb begin
        w_unit_start  = (w_next_state == S_ISSUE) ? w_tgt_oh : '0;
        w_unit_param  = (w_next_state == S_ISSUE) ? w_payload : r_unit_param;
        w_exe         = (w_next_state == S_DONE);
        w_halted      = (w_next_state == S_HALT);
        w_idle        = (w_next_state == S_IDLE);
        w_illegal_set = (r_state == S_DECODE) && (w_kind == K_ILLEGAL);
        w_timeout_set = (r_state == S_WAIT) && !w_tgt_done && w_tc;
        w_overrun_set = i_instruction_enable && (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unit_start  <= '0;
            r_unit_param  <= '0;
            r_exe         <= 1'b0;
            r_halted      <= 1'b0;
            r_idle        <= 1'b1;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_unit_start  <= w_unit_start;
            r_unit_param  <= w_unit_param;
            r_exe         <= w_exe;
            r_halted      <= w_halted;
            r_idle        <= w_idle;
            r_err_illegal <= r_err_illegal | w_illegal_set;
            r_err_timeout <= r_err_timeout | w_timeout_set;
            r_err_overrun <= r_err_overrun | w_overrun_set;
        end
    end

    assign o_unit_start      = r_unit_start;
    assign o_unit_param      = r_unit_param;
    assign o_instr_exe_state = r_exe;
    assign o_halted          = r_halted;
    assign o_dispatcher_idle = r_idle;
    assign o_err_illegal     = r_err_illegal;
    assign o_err_timeout     = r_err_timeout;
    assign o_err_overrun     = r_err_overrun;

endmodule

// File: tb/tb_instr_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_instr_dispatcher
// Directed scenarios for instr_dispatcher. Stimulus pushes the expected start
// and retire events (with their cycle numbers) into a queue; a monitor pops
// and compares whenever the DUT pulses unit_start or instr_exe_state.
// -----------------------------------------------------------------------------
module tb_instr_dispatcher;

    localparam int NU = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [63:0]   ctr = '0;
    logic [NU-1:0] busy = '0;
    logic [NU-1:0] done = '0;

    logic [NU-1:0] o_unit_start;
    logic [59:0]   o_unit_param;
    logic          o_instr_exe_state;
    logic          o_halted;
    logic          o_err_illegal;
    logic          o_err_timeout;
    logic          o_err_overrun;
    logic          o_dispatcher_idle;

    instr_dispatcher #(
        .NUM_UNITS (NU),
        .TIMEOUT_W (TW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_instruction_enable (en),
        .i_ctr                (ctr),
        .i_unit_busy          (busy),
        .i_unit_done          (done),
        .o_unit_start         (o_unit_start),
        .o_unit_param         (o_unit_param),
        .o_instr_exe_state    (o_instr_exe_state),
        .o_halted             (o_halted),
        .o_err_illegal        (o_err_illegal),
        .o_err_timeout        (o_err_timeout),
        .o_err_overrun        (o_err_overrun),
        .o_dispatcher_idle    (o_dispatcher_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_start;
        logic [3:0]  unit;
        logic [59:0] param;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_start(input logic [3:0] unit, input logic [59:0] param, input int c);
        exp_t e;
        e.is_start = 1'b1; e.unit = unit; e.param = param; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic push_retire(input int c);
        exp_t e;
        e.is_start = 1'b0; e.unit = '0; e.param = '0; e.cyc = c;
        q.push_back(e);
    endtask

    // ------------------------------------------------------------- monitor
    exp_t m_e;
    always @(negedge clk) begin
        if (o_unit_start != '0) begin
            if (q.size() == 0)
                check("unexpected_start", 64'(o_unit_start), 64'd0);
            else begin
                m_e = q.pop_front();
                check("start_kind",  64'(o_unit_start != '0), 64'(m_e.is_start));
                check("start_unit",  64'(o_unit_start), 64'(m_e.unit));
                check("start_param", 64'(o_unit_param), 64'(m_e.param));
                check("start_cycle", 64'(cyc), 64'(m_e.cyc));
            end
        end
        if (o_instr_exe_state) begin
            if (q.size() == 0)
                check("unexpected_retire", 64'(o_instr_exe_state), 64'd0);
            else begin
                m_e = q.pop_front();
                check("retire_kind",  64'(o_unit_start != '0), 64'(m_e.is_start));
                check("retire_cycle", 64'(cyc), 64'(m_e.cyc));
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c, s, b, d;

    initial begin
        // Reset state
        step();
        step();
        check("rst_idle",   64'(o_dispatcher_idle), 64'd1);
        check("rst_start",  64'(o_unit_start), 64'd0);
        check("rst_exe",    64'(o_instr_exe_state), 64'd0);
        check("rst_param",  64'(o_unit_param), 64'd0);
        check("rst_halted", 64'(o_halted), 64'd0);
        check("rst_errs",   64'({o_err_illegal, o_err_timeout, o_err_overrun}), 64'd0);
        rst = 1'b0;
        wait_until(cyc + 3);

        // 1: CONV, unit 1 free, done 5 cycles after start
        step();
        en = 1'b1; ctr = 64'h2000_0000_0000_0ABC; c = cyc; s = c + 2;
        push_start(4'b0010, 60'hABC, s);
        push_retire(s + 6);
        step();
        en = 1'b0;
        wait_until(s + 2);
        done = 4'b0001;                       // non-target completion, ignored
        step();
        done = 4'b0000;
        wait_until(s + 5);
        done = 4'b0010;
        step();
        done = 4'b0000;
        wait_until(s + 7);
        done = 4'b1111;                       // completion while idle, ignored
        step();
        done = 4'b0000;
        check("conv_idle", 64'(o_dispatcher_idle), 64'd1);
        check("conv_errs", 64'({o_err_illegal, o_err_timeout, o_err_overrun}), 64'd0);

        // 2: STORE stalled on unit 3 busy for 10 cycles
        step();
        en = 1'b1; ctr = 64'h4123_4567_89AB_CDEF; busy = 4'b1000; c = cyc;
        step();
        en = 1'b0;
        wait_until(c + 10);
        busy = 4'b0000; b = cyc;
        push_start(4'b1000, 60'h123_4567_89AB_CDEF, b + 1);
        push_retire(b + 5);
        wait_until(b + 4);
        done = 4'b1000;
        step();
        done = 4'b0000;
        wait_until(b + 6);

        // 3: BARRIER draining units 0 and 2
        step();
        en = 1'b1; ctr = 64'hE000_0000_0000_0000; busy = 4'b0101; c = cyc; d = c + 2;
        push_retire(d + 8);
        step();
        en = 1'b0;
        wait_until(d + 3);
        busy = 4'b0100;
        wait_until(d + 7);
        busy = 4'b0000;
        wait_until(d + 9);
        check("barrier_param_held", 64'(o_unit_param), 64'h0123_4567_89AB_CDEF);

        // 4: illegal opcode 0x7, then NOP back-to-back
        step();
        en = 1'b1; ctr = 64'h7000_0000_0000_0001; c = cyc;
        push_retire(c + 2);
        step();
        en = 1'b0;
        wait_until(c + 3);
        en = 1'b1; ctr = 64'h0000_0000_0000_0000;
        push_retire(c + 5);
        step();
        en = 1'b0;
        wait_until(c + 7);
        check("illegal_flag",      64'(o_err_illegal), 64'd1);
        check("b2b_no_overrun",    64'(o_err_overrun), 64'd0);
        check("illegal_no_timeout", 64'(o_err_timeout), 64'd0);

        // 5a: LOAD never completes, times out after 15 wait cycles
        step();
        en = 1'b1; ctr = 64'h1000_0000_0000_0005; c = cyc;
        push_start(4'b0001, 60'h5, c + 2);
        push_retire(c + 18);
        step();
        en = 1'b0;
        wait_until(c + 17);
        check("timeout_not_early", 64'(o_err_timeout), 64'd0);
        wait_until(c + 19);
        check("timeout_flag",      64'(o_err_timeout), 64'd1);

        do_reset();
        check("reset_clears_timeout", 64'(o_err_timeout), 64'd0);
        check("reset_clears_illegal", 64'(o_err_illegal), 64'd0);

        // 5b: LOAD done exactly at terminal count, completion wins
        step();
        en = 1'b1; ctr = 64'h1000_0000_0000_0006; c = cyc;
        push_start(4'b0001, 60'h6, c + 2);
        push_retire(c + 18);
        step();
        en = 1'b0;
        wait_until(c + 17);
        done = 4'b0001;
        step();
        done = 4'b0000;
        wait_until(c + 20);
        check("tc_done_no_timeout", 64'(o_err_timeout), 64'd0);

        // 6: HALT, then enables are overruns and nothing retires
        step();
        en = 1'b1; ctr = 64'hF000_0000_0000_0000; c = cyc;
        step();
        en = 1'b0;
        wait_until(c + 3);
        check("halt_flag", 64'(o_halted), 64'd1);
        wait_until(c + 4);
        en = 1'b1; ctr = 64'h2000_0000_0000_0001;
        step();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        en = 1'b0;
        wait_until(c + 12);
        check("halt_sticky",   64'(o_halted), 64'd1);
        check("halt_overrun",  64'(o_err_overrun), 64'd1);
        check("halt_not_idle", 64'(o_dispatcher_idle), 64'd0);

        do_reset();
        check("reset_clears_halt", 64'(o_halted), 64'd0);

        // 7: asynchronous reset in the middle of WAIT
        step();
        en = 1'b1; ctr = 64'h1000_0000_0000_0777; c = cyc;
        push_start(4'b0001, 60'h777, c + 2);
        step();
        en = 1'b0;
        wait_until(c + 5);
        en = 1'b1;                            // overrun during WAIT
        step();
        en = 1'b0;
        step();
        check("pre_rst_overrun", 64'(o_err_overrun), 64'd1);
        check("pre_rst_param",   64'(o_unit_param), 64'h777);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_param",   64'(o_unit_param), 64'd0);
        check("async_rst_overrun", 64'(o_err_overrun), 64'd0);
        check("async_rst_idle",    64'(o_dispatcher_idle), 64'd1);
        check("async_rst_outs",    64'({o_unit_start, o_instr_exe_state, o_halted,
                                        o_err_illegal, o_err_timeout}), 64'd0);
        step();
        step();
        rst = 1'b0;
        wait_until(cyc + 20);                 // no start or retire may follow release
        check("post_rst_idle", 64'(o_dispatcher_idle), 64'd1);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_dispatcher.md
Name: instr_dispatcher

Overview:
Sits between the top-level fetch FSM and the execution units (load, conv, pool, store).
- Captures each 64-bit instruction presented on the instruction bus when instruction_enable pulses.
- Decodes the opcode and issues a one-cycle start to the target unit, waiting until that unit is free first.
- Waits for the unit's done, then pulses instr_exe_state so the fetch FSM advances to the next instruction.
- Also handles NOP, BARRIER (drain all units), HALT, illegal-opcode and timeout conditions.

Parameters:
NUM_UNITS, 4, number of execution units; unit index = opcode-1 for opcodes 1..NUM_UNITS
TIMEOUT_W, 16, width of the per-instruction wait counter; timeout fires at 2^TIMEOUT_W-1 cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
instruction_enable  in  1  one-cycle pulse; ctr is valid in the same cycle
ctr  in  64  instruction: [63:60] opcode, [59:0] payload
unit_busy  in  NUM_UNITS  per-unit busy level
unit_done  in  NUM_UNITS  per-unit one-cycle completion pulse
unit_start  out  NUM_UNITS  one-hot, one-cycle start pulse
unit_param  out  60  latched payload; held stable from ISSUE until the next capture
instr_exe_state  out  1  one-cycle pulse: current instruction retired
halted  out  1  HALT reached; sticky until rst
err_illegal  out  1  sticky: undefined opcode seen
err_timeout  out  1  sticky: a unit did not complete in time
err_overrun  out  1  sticky: instruction_enable arrived while not IDLE
dispatcher_idle  out  1  high in IDLE

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0 except dispatcher_idle=1; instr_reg=0; wait counter=0. Reset mid-operation aborts immediately. No start or exe pulse is generated on reset release.
- Opcodes:
  - 0 NOP
  - 1 LOAD → unit 0
  - 2 CONV → unit 1
  - 3 POOL → unit 2
  - 4 STORE → unit 3
  - 0xE BARRIER
  - 0xF HALT
  - all others illegal
- IDLE: when instruction_enable=1, latch ctr into instr_reg and go to DECODE.
- DECODE, by opcode:
  - NOP → DONE.
  - Unit opcode, unit_busy[tgt]=1 → stay in DECODE (stall, no start).
  - Unit opcode, unit_busy[tgt]=0 → ISSUE.
  - BARRIER → DRAIN.
  - HALT → HALT.
  - Illegal → set err_illegal, go to DONE (instruction skipped, still retired).
- ISSUE: unit_start[tgt]=1 for exactly this cycle; unit_param=instr_reg[59:0]; counter cleared → WAIT.
- WAIT:
  - unit_done[tgt]=1 → DONE.
  - Otherwise counter+1; when counter reaches all-ones → set err_timeout, go to DONE.
  - If done and terminal count occur in the same cycle, done wins and err_timeout is not set.
- DRAIN: unit_busy==0 → DONE; otherwise stay. No timeout applies in DRAIN.
- DONE: instr_exe_state=1 for one cycle → IDLE.
- HALT: halted=1; instr_exe_state is never pulsed; the state is left only via rst.
- Ignored inputs:
  - unit_done bits outside WAIT, or for a non-target unit.
  - instruction_enable outside IDLE; this sets err_overrun and does not change instr_reg.
- Latency, enable to start: 2 cycles when the unit is free.
- Latency, done to instr_exe_state: 1 cycle.
- Latency, NOP: instr_exe_state 2 cycles after enable.
- Minimum back-to-back spacing: the next enable is accepted in the cycle after the DONE cycle.
- Counter width is TIMEOUT_W, unsigned, saturates at terminal count.
- All outputs are registered.

Decomposition:
- Package dispatcher_pkg:
  - opcode localparams (OP_NOP, OP_LOAD, OP_CONV, OP_POOL, OP_STORE, OP_BARRIER, OP_HALT)
  - state encoding (IDLE, DECODE, ISSUE, WAIT, DRAIN, DONE, HALT)
  - field positions OPC_HI/OPC_LO/PAYLOAD_W
- One natural sub-module, dispatch_timeout_cnt:
  - clear/enable inputs, saturating TIMEOUT_W counter, terminal-count output.

Test Plan:
- CONV 0x2_000000000000ABC, unit 1 idle, done 5 cycles after start → unit_start=4'b0010 at enable+2; unit_param=0xABC; instr_exe_state at done+1; no errors.
- STORE with unit_busy[3]=1 for 10 cycles → no unit_start during the stall; start exactly 1 cycle after busy drops; retire after done.
- BARRIER with unit_busy=4'b0101, clearing at cycles 3 and 7 → instr_exe_state at cycle 8 after DRAIN entry; unit_start stays 0.
- Opcode 0x7, then a NOP → err_illegal=1 (sticky); both instructions retire with one instr_exe_state each; no starts.
- TIMEOUT_W=4, LOAD never done → err_timeout=1 and instr_exe_state after 15 WAIT cycles. Second run with done at terminal count → no err_timeout.
- HALT, then enable pulses → halted=1, err_overrun=1, no instr_exe_state. Assert rst mid-WAIT of a later run → all outputs 0 asynchronously, dispatcher_idle=1.
